// File: rtl/ctrl_pkg.sv
// Shared definitions for the control sequencer of the 8-bit bus CPU:
// opcode encodings, T-state constants, control-word bit layout and the
// per-opcode last execute step used by the early-end build option.
package ctrl_pkg;

  localparam int OPCODE_W_DEF = 4;
  localparam int STEP_W_DEF   = 3;

  // Opcode encodings (IR upper nibble)
  localparam logic [OPCODE_W_DEF-1:0] OP_NOP = 4'b0000;
  localparam logic [OPCODE_W_DEF-1:0] OP_LDA = 4'b0001;
  localparam logic [OPCODE_W_DEF-1:0] OP_ADD = 4'b0010;
  localparam logic [OPCODE_W_DEF-1:0] OP_SUB = 4'b0011;
  localparam logic [OPCODE_W_DEF-1:0] OP_STA = 4'b0100;
  localparam logic [OPCODE_W_DEF-1:0] OP_LDI = 4'b0101;
  localparam logic [OPCODE_W_DEF-1:0] OP_JMP = 4'b0110;
  localparam logic [OPCODE_W_DEF-1:0] OP_JC  = 4'b0111;
  localparam logic [OPCODE_W_DEF-1:0] OP_JZ  = 4'b1000;
  localparam logic [OPCODE_W_DEF-1:0] OP_OUT = 4'b1110;
  localparam logic [OPCODE_W_DEF-1:0] OP_HLT = 4'b1111;

  // T-state values of the step counter
  localparam logic [STEP_W_DEF-1:0] T0 = 3'd0;
  localparam logic [STEP_W_DEF-1:0] T1 = 3'd1;
  localparam logic [STEP_W_DEF-1:0] T2 = 3'd2;
  localparam logic [STEP_W_DEF-1:0] T3 = 3'd3;
  localparam logic [STEP_W_DEF-1:0] T4 = 3'd4;

  // Control-word bit positions
  localparam int CW_PC_OUT     = 0;
  localparam int CW_PC_INC     = 1;
  localparam int CW_PC_LOAD    = 2;
  localparam int CW_MAR_LOAD   = 3;
  localparam int CW_RAM_OUT    = 4;
  localparam int CW_RAM_LOAD   = 5;
  localparam int CW_IR_LOAD    = 6;
  localparam int CW_IR_OUT     = 7;
  localparam int CW_IR_ZEROIZE = 8;
  localparam int CW_A_LOAD     = 9;
  localparam int CW_A_OUT      = 10;
  localparam int CW_B_LOAD     = 11;
  localparam int CW_ALU_OUT    = 12;
  localparam int CW_ALU_SUB    = 13;
  localparam int CW_FLAGS_LOAD = 14;
  localparam int CW_OUT_LOAD   = 15;
  localparam int CW_W          = 16;

  typedef enum logic {
    ST_RUN,
    ST_HALTED
  } seq_state_t;

  // Last step that carries work for an opcode; untaken branches, NOP and
  // undefined opcodes have nothing after the fetch, so they end at T1.
  function automatic logic [STEP_W_DEF-1:0] last_step(
    input logic [OPCODE_W_DEF-1:0] op,
    input logic                    cf,
    input logic                    zf
  );
    case (op)
      OP_LDA, OP_STA:                 last_step = T3;
      OP_ADD, OP_SUB:                 last_step = T4;
      OP_LDI, OP_JMP, OP_OUT, OP_HLT: last_step = T2;
      OP_JC:                          last_step = cf ? T2 : T1;
      OP_JZ:                          last_step = zf ? T2 : T1;
      default:                        last_step = T1;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_microcode_rom.sv
// Combinational microcode table: {opcode, step, cf, zf} -> control word.
// Only one bus driver (pc_out, ram_out, ir_out, a_out, alu_out) is set per
// entry, and ir_out is always paired with ir_zeroize so only the operand
// nibble reaches the bus.
module ctrl_microcode_rom
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = OPCODE_W_DEF,
  parameter int STEP_W   = STEP_W_DEF
) (
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [STEP_W-1:0]   step,
  input  logic                cf,
  input  logic                zf,
  output logic [CW_W-1:0]     cw
);

  // Decode the current step: fetch is shared, execute depends on opcode/flags
  always_comb begin
    cw = '0;
    if (step == T0) begin
      cw[CW_PC_OUT]   = 1'b1;
      cw[CW_MAR_LOAD] = 1'b1;
    end else if (step == T1) begin
      cw[CW_RAM_OUT]  = 1'b1;
      cw[CW_IR_LOAD]  = 1'b1;
      cw[CW_PC_INC]   = 1'b1;
    end else begin
      case (opcode)
        OP_LDA: begin
          if (step == T2) begin
            cw[CW_IR_OUT]     = 1'b1;
            cw[CW_IR_ZEROIZE] = 1'b1;
            cw[CW_MAR_LOAD]   = 1'b1;
          end else if (step == T3) begin
            cw[CW_RAM_OUT]    = 1'b1;
            cw[CW_A_LOAD]     = 1'b1;
          end
        end
        OP_ADD, OP_SUB: begin
          if (step == T2) begin
            cw[CW_IR_OUT]     = 1'b1;
            cw[CW_IR_ZEROIZE] = 1'b1;
            cw[CW_MAR_LOAD]   = 1'b1;
          end else if (step == T3) begin
            cw[CW_RAM_OUT]    = 1'b1;
            cw[CW_B_LOAD]     = 1'b1;
          end else if (step == T4) begin
            cw[CW_ALU_OUT]    = 1'b1;
            cw[CW_A_LOAD]     = 1'b1;
            cw[CW_FLAGS_LOAD] = 1'b1;
            cw[CW_ALU_SUB]    = (opcode == OP_SUB);
          end
        end
        OP_STA: begin
          if (step == T2) begin
            cw[CW_IR_OUT]     = 1'b1;
            cw[CW_IR_ZEROIZE] = 1'b1;
            cw[CW_MAR_LOAD]   = 1'b1;
          end else if (step == T3) begin
            cw[CW_A_OUT]      = 1'b1;
            cw[CW_RAM_LOAD]   = 1'b1;
          end
        end
        OP_LDI: begin
          if (step == T2) begin
            cw[CW_IR_OUT]     = 1'b1;
            cw[CW_IR_ZEROIZE] = 1'b1;
            cw[CW_A_LOAD]     = 1'b1;
          end
        end
        OP_JMP, OP_JC, OP_JZ: begin
          if ((step == T2) &&
              ((opcode == OP_JMP) || ((opcode == OP_JC) && cf) ||
               ((opcode == OP_JZ) && zf))) begin
            cw[CW_IR_OUT]     = 1'b1;
            cw[CW_IR_ZEROIZE] = 1'b1;
            cw[CW_PC_LOAD]    = 1'b1;
          end
        end
        OP_OUT: begin
          if (step == T2) begin
            cw[CW_A_OUT]      = 1'b1;
            cw[CW_OUT_LOAD]   = 1'b1;
          end
        end
        default: cw = '0;
      endcase
    end
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Microcode sequencer for the 8-bit bus CPU. Holds the T-state counter and
// the RUN/HALTED state, gates the microcode control word with reset, pause
// and halt, and fans it out to the register strobes.
// Build option: define CTRL_EARLY_END_EN to return to T0 right after the
// last step of an instruction that carries work, instead of always T0..T4.
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int STEP_W   = 3
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [OPCODE_W-1:0] i_opcode,
  input  logic                i_cf,
  input  logic                i_zf,
  input  logic                i_pause,
  output logic [STEP_W-1:0]   o_step,
  output logic                o_halted,
  output logic                o_pc_out,
  output logic                o_pc_inc,
  output logic                o_pc_load,
  output logic                o_mar_load,
  output logic                o_ram_out,
  output logic                o_ram_load,
  output logic                o_ir_load,
  output logic                o_ir_out,
  output logic                o_ir_zeroize,
  output logic                o_a_load,
  output logic                o_a_out,
  output logic                o_b_load,
  output logic                o_alu_out,
  output logic                o_alu_sub,
  output logic                o_flags_load,
  output logic                o_out_load
);

  seq_state_t          state;
  logic [STEP_W-1:0]   step;
  logic [STEP_W-1:0]   end_step;
  logic [CW_W-1:0]     rom_cw;
  logic [CW_W-1:0]     cw;
  logic                strobe_en;

  ctrl_microcode_rom #(
    .OPCODE_W (OPCODE_W),
    .STEP_W   (STEP_W)
  ) u_rom (
    .opcode (i_opcode),
    .step   (step),
    .cf     (i_cf),
    .zf     (i_zf),
    .cw     (rom_cw)
  );

`ifdef CTRL_EARLY_END_EN
  assign end_step = last_step(i_opcode, i_cf, i_zf);
`else
  assign end_step = T4;
`endif

  assign strobe_en = !i_rst && !i_pause && (state == ST_RUN);
  assign cw        = strobe_en ? rom_cw : '0;

  // Step counter and RUN/HALTED state; a halt freezes the step at T2
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      step  <= T0;
      state <= ST_RUN;
    end else if ((state == ST_RUN) && !i_pause) begin
      if ((step == T2) && (i_opcode == OP_HLT)) begin
        state <= ST_HALTED;
      end else if ((step >= end_step) || (step >= T4)) begin
        step  <= T0;
      end else begin
        step  <= step + 1'b1;
      end
    end
  end

  assign o_step       = step;
  assign o_halted     = (state == ST_HALTED);
  assign o_pc_out     = cw[CW_PC_OUT];
  assign o_pc_inc     = cw[CW_PC_INC];
  assign o_pc_load    = cw[CW_PC_LOAD];
  assign o_mar_load   = cw[CW_MAR_LOAD];
  assign o_ram_out    = cw[CW_RAM_OUT];
  assign o_ram_load   = cw[CW_RAM_LOAD];
  assign o_ir_load    = cw[CW_IR_LOAD];
  assign o_ir_out     = cw[CW_IR_OUT];
  assign o_ir_zeroize = cw[CW_IR_ZEROIZE];
  assign o_a_load     = cw[CW_A_LOAD];
  assign o_a_out      = cw[CW_A_OUT];
  assign o_b_load     = cw[CW_B_LOAD];
  assign o_alu_out    = cw[CW_ALU_OUT];
  assign o_alu_sub    = cw[CW_ALU_SUB];
  assign o_flags_load = cw[CW_FLAGS_LOAD];
  assign o_out_load   = cw[CW_OUT_LOAD];

endmodule
